// File: rtl/cnu_pkg.sv
// Shared definitions for the check-node units: magnitude width default,
// saturation constant and index-width helpers, plus the row-close cause type.
package cnu_pkg;

   localparam int QUAN_SIZE_DEF = 3;

   typedef enum logic [1:0] {
      CLOSE_NONE   = 2'b00,
      CLOSE_LAST   = 2'b01,
      CLOSE_DEGREE = 2'b10
   } close_e;

   // All-ones value of a w-bit magnitude, used as the "nothing seen yet" level.
   function automatic logic [31:0] sat_ones(input int w);
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic int idx_width(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/min2_update.sv
// Combinational two-minimum update of (m1,i1,m2,i2) with a new value v at position p.
// The i2 path exists only when SERIAL_MIN2_SECOND_INDEX_EN is defined.
module min2_update
   import cnu_pkg::*;
#(
   parameter int QUAN_SIZE = QUAN_SIZE_DEF,
   parameter int IDX_W     = 4
) (
   input  logic [QUAN_SIZE-1:0] m1_i,
   input  logic [IDX_W-1:0]     i1_i,
   input  logic [QUAN_SIZE-1:0] m2_i,
   input  logic [QUAN_SIZE-1:0] v_i,
   input  logic [IDX_W-1:0]     p_i,
   output logic [QUAN_SIZE-1:0] m1_o,
   output logic [IDX_W-1:0]     i1_o,
   output logic [QUAN_SIZE-1:0] m2_o
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
   ,
   input  logic [IDX_W-1:0]     i2_i,
   output logic [IDX_W-1:0]     i2_o
`endif
);

   // Strict compares: on ties the incumbent (earlier position) is kept.
   always_comb begin
      m1_o = m1_i;
      i1_o = i1_i;
      m2_o = m2_i;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      i2_o = i2_i;
`endif
      if (v_i < m1_i) begin
         m2_o = m1_i;
         m1_o = v_i;
         i1_o = p_i;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         i2_o = i1_i;
`endif
      end else if (v_i < m2_i) begin
         m2_o = v_i;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         i2_o = p_i;
`endif
      end else begin
         m1_o = m1_i;
         m2_o = m2_i;
      end
   end

endmodule

// File: rtl/serial_min2_tracker.sv
// Streaming two-minimum tracker over serially arriving check-node rows.
// Define SERIAL_MIN2_SECOND_INDEX_EN to add the second_min_index output.
module serial_min2_tracker
   import cnu_pkg::*;
#(
   parameter int QUAN_SIZE = QUAN_SIZE_DEF,
   parameter int DEGREE    = 10
) (
   input  logic                         sys_clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [QUAN_SIZE-1:0]         in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [QUAN_SIZE-1:0]         m1,
   output logic [QUAN_SIZE-1:0]         m2,
   output logic [idx_width(DEGREE)-1:0] min_index,
   output logic                         deg_err
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
   ,
   output logic [idx_width(DEGREE)-1:0] second_min_index
`endif
);

   localparam int                   IDX_W    = idx_width(DEGREE);
   localparam logic [QUAN_SIZE-1:0] MAG_MAX  = QUAN_SIZE'(sat_ones(QUAN_SIZE));
   localparam logic [IDX_W:0]       LAST_POS = (IDX_W+1)'(DEGREE - 1);
   localparam logic [IDX_W:0]       CNT_ONE  = (IDX_W+1)'(1);

   logic [IDX_W:0]       cnt_q,    cnt_d;
   logic [QUAN_SIZE-1:0] acc_m1_q, acc_m1_d;
   logic [QUAN_SIZE-1:0] acc_m2_q, acc_m2_d;
   logic [IDX_W-1:0]     acc_i1_q, acc_i1_d;
   logic                 out_valid_q, out_valid_d;
   logic [QUAN_SIZE-1:0] m1_q, m1_d;
   logic [QUAN_SIZE-1:0] m2_q, m2_d;
   logic [IDX_W-1:0]     i1_q, i1_d;
   logic                 deg_err_q, deg_err_d;

   logic                 accept_s;
   logic                 close_s;
   close_e               close_cause_s;
   logic [IDX_W-1:0]     pos_s;
   logic [QUAN_SIZE-1:0] seed_m1_s, seed_m2_s, upd_m1_s, upd_m2_s;
   logic [IDX_W-1:0]     seed_i1_s, upd_i1_s;

`ifdef SERIAL_MIN2_SECOND_INDEX_EN
   logic [IDX_W-1:0]     acc_i2_q, acc_i2_d;
   logic [IDX_W-1:0]     i2_q, i2_d;
   logic [IDX_W-1:0]     seed_i2_s, upd_i2_s;
`endif

   assign in_ready  = ~out_valid_q | out_ready;
   assign accept_s  = in_valid & in_ready;
   assign pos_s     = cnt_q[IDX_W-1:0];
   assign close_s   = (close_cause_s != CLOSE_NONE);
   assign out_valid = out_valid_q;
   assign m1        = m1_q;
   assign m2        = m2_q;
   assign min_index = i1_q;
   assign deg_err   = deg_err_q;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
   assign second_min_index = i2_q;
`endif

   // Seeding both minima with all-ones makes the first beat a plain update at position 0.
   always_comb begin
      seed_m1_s = acc_m1_q;
      seed_m2_s = acc_m2_q;
      seed_i1_s = acc_i1_q;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      seed_i2_s = acc_i2_q;
`endif
      if (cnt_q == '0) begin
         seed_m1_s = MAG_MAX;
         seed_m2_s = MAG_MAX;
         seed_i1_s = '0;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         seed_i2_s = '0;
`endif
      end else begin
         seed_m1_s = acc_m1_q;
         seed_m2_s = acc_m2_q;
      end
   end

   min2_update #(
      .QUAN_SIZE(QUAN_SIZE),
      .IDX_W    (IDX_W)
   ) u_min2_update (
      .m1_i(seed_m1_s),
      .i1_i(seed_i1_s),
      .m2_i(seed_m2_s),
      .v_i (in_data),
      .p_i (pos_s),
      .m1_o(upd_m1_s),
      .i1_o(upd_i1_s),
      .m2_o(upd_m2_s)
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      ,
      .i2_i(seed_i2_s),
      .i2_o(upd_i2_s)
`endif
   );

   // Row close cause: explicit last beat, or forced at the DEGREE-th beat.
   always_comb begin
      close_cause_s = CLOSE_NONE;
      if (!accept_s) begin
         close_cause_s = CLOSE_NONE;
      end else if (in_last) begin
         close_cause_s = CLOSE_LAST;
      end else if (cnt_q == LAST_POS) begin
         close_cause_s = CLOSE_DEGREE;
      end else begin
         close_cause_s = CLOSE_NONE;
      end
   end

   // Accumulator and beat counter next state.
   always_comb begin
      cnt_d    = cnt_q;
      acc_m1_d = acc_m1_q;
      acc_m2_d = acc_m2_q;
      acc_i1_d = acc_i1_q;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      acc_i2_d = acc_i2_q;
`endif
      if (accept_s) begin
         acc_m1_d = upd_m1_s;
         acc_m2_d = upd_m2_s;
         acc_i1_d = upd_i1_s;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         acc_i2_d = upd_i2_s;
`endif
         if (close_s) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Result registers load only on close; a close wins over a same-cycle consume.
   always_comb begin
      out_valid_d = out_valid_q;
      m1_d        = m1_q;
      m2_d        = m2_q;
      i1_d        = i1_q;
      deg_err_d   = deg_err_q;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      i2_d        = i2_q;
`endif
      if (close_s) begin
         out_valid_d = 1'b1;
         m1_d        = upd_m1_s;
         m2_d        = upd_m2_s;
         i1_d        = upd_i1_s;
         deg_err_d   = (close_cause_s == CLOSE_DEGREE);
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         i2_d        = upd_i2_s;
`endif
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         cnt_q       <= '0;
         acc_m1_q    <= '0;
         acc_m2_q    <= '0;
         acc_i1_q    <= '0;
         out_valid_q <= 1'b0;
         m1_q        <= '0;
         m2_q        <= '0;
         i1_q        <= '0;
         deg_err_q   <= 1'b0;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         acc_i2_q    <= '0;
         i2_q        <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         acc_m1_q    <= acc_m1_d;
         acc_m2_q    <= acc_m2_d;
         acc_i1_q    <= acc_i1_d;
         out_valid_q <= out_valid_d;
         m1_q        <= m1_d;
         m2_q        <= m2_d;
         i1_q        <= i1_d;
         deg_err_q   <= deg_err_d;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
         acc_i2_q    <= acc_i2_d;
         i2_q        <= i2_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_min2_tracker.sv
// Scoreboard bench for serial_min2_tracker: directed rows, stall, mid-row reset, random rows.
`timescale 1ns/1ps
module tb_serial_min2_tracker;

   localparam int Q   = 3;
   localparam int DEG = 10;
   localparam int IW  = 4;
   localparam int MAXV = 7;

   logic          sys_clk = 1'b0;
   logic          rstn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          out_ready = 1'b0;
   logic [Q-1:0]  in_data = '0;
   logic          in_ready, out_valid, deg_err;
   logic [Q-1:0]  m1, m2;
   logic [IW-1:0] min_index;
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
   logic [IW-1:0] second_min_index;
`endif

   serial_min2_tracker #(.QUAN_SIZE(Q), .DEGREE(DEG)) dut (
      .sys_clk  (sys_clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .m1       (m1),
      .m2       (m2),
      .min_index(min_index),
      .deg_err  (deg_err)
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      ,
      .second_min_index(second_min_index)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int m1;
      int i1;
      int m2;
      int i2;
      int de;
   } res_t;

   res_t sb[$];
   int   stim[$];
   int   row_vals[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   close_at = -1;
   int   ready_mode = 2;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: earliest minimum; second = earliest smallest remaining value below all-ones.
   function automatic res_t model(input int vals[$], input int de);
      res_t r;
      int   best;
      best = -1;
      r.m1 = vals[0];
      r.i1 = 0;
      foreach (vals[i]) if (vals[i] < r.m1) begin r.m1 = vals[i]; r.i1 = i; end
      foreach (vals[i])
         if (i != r.i1 && vals[i] < MAXV && (best < 0 || vals[i] < vals[best])) best = i;
      r.m2 = MAXV;
      r.i2 = 0;
      if (best >= 0) begin r.m2 = vals[best]; r.i2 = best; end
      r.de = de;
      return r;
   endfunction

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin @(posedge sys_clk); #1; end
   endtask

   task automatic send_beat(input int d, input bit last);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = Q'(d);
      in_last  = last;
      @(negedge sys_clk);
      while (in_ready !== 1'b1 && w < 100) begin w++; @(negedge sys_clk); end
      if (w >= 100) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      end else begin
         row_vals.push_back(d);
         if (last || row_vals.size() == DEG) begin
            sb.push_back(model(row_vals, last ? 0 : 1));
            row_vals.delete();
            close_at = cyc + 1;
         end
      end
      @(posedge sys_clk); #1;
   endtask

   task automatic send_row(input bit last, input bit gaps);
      for (int i = 0; i < stim.size(); i++) begin
         send_beat(stim[i], last && (i == stim.size() - 1));
         if (gaps && $urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      ready_mode = 2;
      while ((sb.size() != 0 || out_valid !== 1'b0) && w < 200) begin
         @(negedge sys_clk);
         w++;
      end
      if (w >= 200) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      end
   endtask

   // Monitor: checks every presented result against the scoreboard head, pops on consume.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (rstn && cyc == close_at) chk("latency_out_valid", out_valid, 1);
         if (rstn && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result actual=out_valid_1 required=no_result");
            end else begin
               chk("m1", m1, sb[0].m1);
               chk("min_index", min_index, sb[0].i1);
               chk("m2", m2, sb[0].m2);
               chk("deg_err", deg_err, sb[0].de);
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
               chk("second_min_index", second_min_index, sb[0].i2);
`endif
               if (out_ready === 1'b1) void'(sb.pop_front());
            end
         end
         @(posedge sys_clk); #1;
         case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   initial begin
      int t1[5] = '{5, 3, 6, 3, 7};
      int t4a[2] = '{2, 5};
      int t4b[3] = '{6, 1, 4};
      int len;
      bit lst;

      rstn = 1'b0;
      repeat (3) begin @(posedge sys_clk); #1; end
      rstn = 1'b1;
      @(negedge sys_clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_m1", m1, 0);
      chk("reset_m2", m2, 0);
      chk("reset_min_index", min_index, 0);
      chk("reset_deg_err", deg_err, 0);
`ifdef SERIAL_MIN2_SECOND_INDEX_EN
      chk("reset_second_min_index", second_min_index, 0);
`endif
      @(posedge sys_clk); #1;

      // Directed rows with out_ready held high
      stim.delete(); foreach (t1[i]) stim.push_back(t1[i]);
      send_row(1'b1, 1'b0);
      stim.delete(); for (int i = 0; i < 9; i++) stim.push_back(7); stim.push_back(2);
      send_row(1'b0, 1'b0);
      stim.delete(); stim.push_back(4);
      send_row(1'b1, 1'b0);
      idle(1);
      drain();

      // Stall: first result held, second row blocked for three cycles
      ready_mode = 1;
      idle(2);
      stim.delete(); foreach (t4a[i]) stim.push_back(t4a[i]);
      send_row(1'b1, 1'b0);
      fork
         begin
            stim.delete(); foreach (t4b[i]) stim.push_back(t4b[i]);
            send_row(1'b1, 1'b0);
            idle(1);
         end
         begin
            int w;
            w = 0;
            while (out_valid !== 1'b1 && w < 20) begin @(negedge sys_clk); w++; end
            chk("stall_result_seen", out_valid, 1);
            for (int k = 0; k < 3; k++) begin
               chk("stall_in_ready", in_ready, 0);
               @(negedge sys_clk);
            end
            ready_mode = 2;
         end
      join
      drain();

      // Reset in the middle of a row discards it
      send_beat(0, 1'b0);
      send_beat(0, 1'b0);
      idle(1);
      rstn = 1'b0;
      row_vals.delete();
      close_at = -1;
      @(posedge sys_clk); #1;
      rstn = 1'b1;
      @(negedge sys_clk);
      chk("midreset_in_ready", in_ready, 1);
      chk("midreset_out_valid", out_valid, 0);
      @(posedge sys_clk); #1;
      stim.delete(); stim.push_back(1); stim.push_back(0);
      send_row(1'b1, 1'b0);
      idle(1);
      drain();

      // Random rows, random gaps and random backpressure
      ready_mode = 0;
      for (int r = 0; r < 150; r++) begin
         len = $urandom_range(1, DEG);
         lst = (len < DEG) ? 1'b1 : 1'($urandom_range(0, 1));
         stim.delete();
         for (int i = 0; i < len; i++) stim.push_back($urandom_range(0, MAXV));
         send_row(lst, 1'b1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      idle(1);
      drain();
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
